vga_tile_renderer: RTL and testbench
====================================

Name: vga_tile_renderer

Overview:
- Pixel-side responder to the VGA timing generator used by gameController.
- The timing generator initiates each pixel with coordinates and sync/blank strobes. This block reads the game's 32x24 tile grid from the synchronous tile RAM and returns registered RGB, with the sync/blank signals realigned to the same pipeline stage.
- Also pulses frame_start once per frame so game logic can update the grid during vertical blanking.

Parameters:
- TILE_PX, 20, tile edge in pixels (640/20 = 32 columns, 480/20 = 24 rows)
- GRID_W, 32, tiles per row
- GRID_H, 24, tiles per column
- BLINK_FRAMES, 16, frames per food-blink half period

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high
- pix_en  in  1  pixel strobe (one CLOCK_50 cycle in two); the pipeline advances only when high
- x_in  in  10  current pixel column from the timing generator, valid with pix_en
- y_in  in  10  current pixel row, valid with pix_en
- hs_in  in  1  hsync from the timing generator
- vs_in  in  1  vsync from the timing generator
- blank_n_in  in  1  active-video flag from the timing generator
- tile_addr  out  10  tile RAM read address, row*GRID_W+col
- tile_data  in  2  tile RAM read data, 1 clock latency; 0 empty, 1 body, 2 head, 3 food
- VGA_R, VGA_G, VGA_B  out  8 each  pixel colour
- VGA_HS, VGA_VS, VGA_BLANK_N  out  1 each  delayed sync/blank, aligned with RGB
- frame_start  out  1  one-clock pulse at vs_in falling edge

Behaviour:
- Reset values:
  - tile_addr=0; RGB=0; VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0; frame_start=0.
  - Pipeline valid bits, tile counters, blink counter and blink phase all cleared.
- Tile counters (col 5b, sub_x 5b, row 5b, sub_y 5b) replace division:
  - On pix_en with x_in==0: col=0, sub_x=0.
  - On pix_en with x_in==0 and y_in==0: row=0, sub_y=0.
  - On pix_en with x_in==0 and y_in!=0: sub_y advances; at TILE_PX-1 it wraps to 0 and row increments, saturating at GRID_H-1.
  - On pix_en with blank_n_in=1 and x_in!=0: sub_x advances; at TILE_PX-1 it wraps and col increments, saturating at GRID_W-1.
- Pipeline, advancing only on pix_en; all stages hold when pix_en=0:
  - S1: tile_addr <= {row,col}; capture hs/vs/blank and the in-border flag.
  - S2: capture tile_data. RAM data is stable because at least 1 clock elapses between pix_en pulses.
  - S3: colour lookup; register RGB and sync outputs.
- Latency: exactly 3 pix_en strobes from x_in/y_in/hs_in to VGA_* outputs, so syncs and RGB always stay aligned.
- Colour rules, in priority order:
  - blank=0 -> RGB 0.
  - Outer ring of tiles (col 0 or 31, row 0 or 23) -> grey 80/80/80, regardless of tile_data.
  - Code 2 (head) -> 255/255/0.
  - Code 1 (body) -> 0/200/0.
  - Code 3 (food) -> 255/0/0 while blink phase=1, else 0/0/0.
  - Code 0 (empty) -> 0/0/0.
- frame_start:
  - vs_in is registered every clock; frame_start=1 for exactly one CLOCK_50 cycle when prev=1 and cur=0, independent of pix_en.
- Blink:
  - The frame counter increments on each frame_start.
  - At BLINK_FRAMES-1 the counter wraps to 0 and the blink phase toggles.
  - After reset the phase is 0, so food is dark for the first 16 frames.
- Boundary cases:
  - Reset mid-frame: outputs return to reset values on the next edge. Counters resynchronise at the next x_in==0 / y_in==0, and garbage colour before that is masked by blank.
  - pix_en held low: all outputs frozen.
  - x_in beyond 639 during blanking: col saturates, RGB forced 0.

Decomposition:
- Shared package game_pkg:
  - Tile codes TILE_EMPTY/BODY/HEAD/FOOD (2b).
  - GRID_W, GRID_H, TILE_PX.
  - Colour constants.
- One natural sub-module: vga_sync_delay, a parametrised N-stage pix_en-enabled shift register for hs/vs/blank.

Test Plan:
- Reset held 2 clocks mid-line -> RGB=0, VGA_BLANK_N=0, VGA_HS=1, tile_addr=0; after release the first valid colour appears only once x_in==0 has been seen.
- RAM model returns code 2 at address 5*32+7; drive x=140..159, y=100 with blank=1 -> those 20 pixels are 255/255/0, appearing 3 pix_en after input; x=139 and x=160 are not yellow.
- Drive hs_in low at x=656 with pix_en alternating -> VGA_HS goes low exactly 3 pix_en strobes (6 clocks) later, aligned with the RGB of x=656.
- Tile (0,0) written as code 1 -> pixel (5,5) is grey 80/80/80 (border wins); blank=0 pixels are always 0/0/0.
- Food tile at (10,10): pulse vs_in 32 times -> frame_start gives 32 single-clock pulses; food is dark in frames 0-15 and red in frames 16-31.
- pix_en held low for 10 clocks mid-line -> tile_addr, RGB and syncs unchanged throughout; pipeline resumes seamlessly afterwards.

Source files
------------

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared tile codes, grid geometry and colour constants
// Contents: tile codes (2b), grid/tile sizes, blink period, RGB colours,
// and tile_colour() mapping a tile code plus blink phase to RGB.
package game_pkg;

   localparam int TILE_PX      = 20;
   localparam int GRID_W       = 32;
   localparam int GRID_H       = 24;
   localparam int BLINK_FRAMES = 16;

   typedef enum logic [1:0] {
      TILE_EMPTY = 2'd0,
      TILE_BODY  = 2'd1,
      TILE_HEAD  = 2'd2,
      TILE_FOOD  = 2'd3
   } tile_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   localparam rgb_t COL_BLACK  = 24'h000000;
   localparam rgb_t COL_GREY   = 24'h505050;
   localparam rgb_t COL_YELLOW = 24'hFFFF00;
   localparam rgb_t COL_GREEN  = 24'h00C800;
   localparam rgb_t COL_RED    = 24'hFF0000;

   // Colour of an interior tile; food is only lit during the "on" blink phase.
   function automatic rgb_t tile_colour(input logic [1:0] code, input logic blink_on);
      case (tile_t'(code))
         TILE_HEAD: return COL_YELLOW;
         TILE_BODY: return COL_GREEN;
         TILE_FOOD: return blink_on ? COL_RED : COL_BLACK;
         default:   return COL_BLACK;
      endcase
   endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// rtl/vga_sync_delay.sv - N-stage enable-gated shift register for sync/blank strobes
// Ports: clk, reset (sync, active-high, loads RESET_VAL), en (advance),
// d (W-bit input), q (W-bit output, N enabled steps behind d).
module vga_sync_delay #(
   parameter int           N         = 2,
   parameter int           W         = 3,
   parameter logic [W-1:0] RESET_VAL = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] stage [N];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N; i++) stage[i] <= RESET_VAL;
      end else if (en) begin
         stage[0] <= d;
         for (int i = 1; i < N; i++) stage[i] <= stage[i-1];
      end
   end

   assign q = stage[N-1];

endmodule

// File: rtl/vga_tile_renderer.sv
// rtl/vga_tile_renderer.sv - tile-grid pixel renderer behind the VGA timing generator
// Inputs : CLOCK_50, reset (sync, active-high), pix_en, x_in/y_in, hs_in, vs_in,
//          blank_n_in, tile_data (tile RAM read data, 1-clock latency).
// Outputs: tile_addr (row*32+col), VGA_R/G/B, VGA_HS/VS/BLANK_N (3 pix_en behind
//          the inputs), frame_start (one-clock pulse on vs_in falling edge).
module vga_tile_renderer #(
   parameter int TILE_PX      = game_pkg::TILE_PX,
   parameter int GRID_W       = game_pkg::GRID_W,
   parameter int GRID_H       = game_pkg::GRID_H,
   parameter int BLINK_FRAMES = game_pkg::BLINK_FRAMES
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       pix_en,
   input  logic [9:0] x_in,
   input  logic [9:0] y_in,
   input  logic       hs_in,
   input  logic       vs_in,
   input  logic       blank_n_in,
   output logic [9:0] tile_addr,
   input  logic [1:0] tile_data,
   output logic [7:0] VGA_R,
   output logic [7:0] VGA_G,
   output logic [7:0] VGA_B,
   output logic       VGA_HS,
   output logic       VGA_VS,
   output logic       VGA_BLANK_N,
   output logic       frame_start
);

   import game_pkg::*;

   localparam int FW = $clog2(BLINK_FRAMES);

   logic [4:0] col, sub_x, row, sub_y;
   logic [4:0] col_nxt, sub_x_nxt, row_nxt, sub_y_nxt;
   logic       synced, synced_nxt, border_nxt;
   logic       border1, valid1;
   logic [1:0] tile2;
   logic       border2, valid2;
   logic       hs2, vs2, blank2;
   logic       vs_q, blink;
   logic [FW-1:0] frame_cnt;
   rgb_t       pix_colour;

   // Counter values for the pixel being presented now; they are committed on
   // pix_en and also feed stage 1 directly, so no extra cycle is lost.
   always_comb begin
      col_nxt   = col;
      sub_x_nxt = sub_x;
      row_nxt   = row;
      sub_y_nxt = sub_y;
      if (x_in == 10'd0) begin
         col_nxt   = '0;
         sub_x_nxt = '0;
         if (y_in == 10'd0) begin
            row_nxt   = '0;
            sub_y_nxt = '0;
         end else if (sub_y == 5'(TILE_PX - 1)) begin
            sub_y_nxt = '0;
            if (row != 5'(GRID_H - 1)) row_nxt = row + 5'd1;
         end else begin
            sub_y_nxt = sub_y + 5'd1;
         end
      end else if (blank_n_in) begin
         if (sub_x == 5'(TILE_PX - 1)) begin
            sub_x_nxt = '0;
            if (col != 5'(GRID_W - 1)) col_nxt = col + 5'd1;
         end else begin
            sub_x_nxt = sub_x + 5'd1;
         end
      end
   end

   // Until a line start has been seen after reset the counters mean nothing,
   // so pixels are marked invalid and rendered black.
   assign synced_nxt = synced | (x_in == 10'd0);
   assign border_nxt = (col_nxt == 5'd0) || (col_nxt == 5'(GRID_W - 1)) ||
                       (row_nxt == 5'd0) || (row_nxt == 5'(GRID_H - 1));

   vga_sync_delay #(
      .N         (2),
      .W         (3),
      .RESET_VAL (3'b110)
   ) u_sync_delay (
      .clk   (CLOCK_50),
      .reset (reset),
      .en    (pix_en),
      .d     ({hs_in, vs_in, blank_n_in}),
      .q     ({hs2, vs2, blank2})
   );

   always_comb begin
      pix_colour = COL_BLACK;
      if (valid2 && blank2) begin
         if (border2) pix_colour = COL_GREY;
         else         pix_colour = tile_colour(tile2, blink);
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         col         <= '0;
         sub_x       <= '0;
         row         <= '0;
         sub_y       <= '0;
         synced      <= 1'b0;
         tile_addr   <= '0;
         border1     <= 1'b0;
         valid1      <= 1'b0;
         tile2       <= '0;
         border2     <= 1'b0;
         valid2      <= 1'b0;
         VGA_R       <= '0;
         VGA_G       <= '0;
         VGA_B       <= '0;
         VGA_HS      <= 1'b1;
         VGA_VS      <= 1'b1;
         VGA_BLANK_N <= 1'b0;
      end else if (pix_en) begin
         col         <= col_nxt;
         sub_x       <= sub_x_nxt;
         row         <= row_nxt;
         sub_y       <= sub_y_nxt;
         synced      <= synced_nxt;
         // S1: address the tile RAM
         tile_addr   <= {row_nxt, col_nxt};
         border1     <= border_nxt;
         valid1      <= synced_nxt;
         // S2: RAM answered at least one clock ago
         tile2       <= tile_data;
         border2     <= border1;
         valid2      <= valid1;
         // S3: colour and syncs leave together
         {VGA_R, VGA_G, VGA_B} <= pix_colour;
         VGA_HS      <= hs2;
         VGA_VS      <= vs2;
         VGA_BLANK_N <= blank2;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         vs_q        <= 1'b0;
         frame_start <= 1'b0;
         frame_cnt   <= '0;
         blink       <= 1'b0;
      end else begin
         vs_q        <= vs_in;
         frame_start <= vs_q & ~vs_in;
         if (frame_start) begin
            if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
               frame_cnt <= '0;
               blink     <= ~blink;
            end else begin
               frame_cnt <= frame_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_vga_tile_renderer.sv
// tb/tb_vga_tile_renderer.sv - directed self-checking bench for vga_tile_renderer
module tb_vga_tile_renderer;

   logic       CLOCK_50 = 1'b0;
   logic       reset;
   logic       pix_en;
   logic [9:0] x_in, y_in;
   logic       hs_in, vs_in, blank_n_in;
   logic [9:0] tile_addr;
   logic [1:0] tile_data;
   logic [7:0] VGA_R, VGA_G, VGA_B;
   logic       VGA_HS, VGA_VS, VGA_BLANK_N;
   logic       frame_start;

   logic [1:0]  mem [0:1023];
   logic [23:0] rgb;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          fs_cnt = 0;

   localparam logic [23:0] BLACK  = 24'h000000;
   localparam logic [23:0] GREY   = 24'h505050;
   localparam logic [23:0] YELLOW = 24'hFFFF00;
   localparam logic [23:0] GREEN  = 24'h00C800;
   localparam logic [23:0] RED    = 24'hFF0000;

   vga_tile_renderer dut (
      .CLOCK_50    (CLOCK_50),
      .reset       (reset),
      .pix_en      (pix_en),
      .x_in        (x_in),
      .y_in        (y_in),
      .hs_in       (hs_in),
      .vs_in       (vs_in),
      .blank_n_in  (blank_n_in),
      .tile_addr   (tile_addr),
      .tile_data   (tile_data),
      .VGA_R       (VGA_R),
      .VGA_G       (VGA_G),
      .VGA_B       (VGA_B),
      .VGA_HS      (VGA_HS),
      .VGA_VS      (VGA_VS),
      .VGA_BLANK_N (VGA_BLANK_N),
      .frame_start (frame_start)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   always @(posedge CLOCK_50) tile_data <= mem[tile_addr];

   always @(negedge CLOCK_50) if (frame_start) fs_cnt <= fs_cnt + 1;

   assign rgb = {VGA_R, VGA_G, VGA_B};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic strobe(input int x, input int y, input logic hs, input logic bl);
      @(negedge CLOCK_50);
      x_in       = 10'(x);
      y_in       = 10'(y);
      hs_in      = hs;
      blank_n_in = bl;
      pix_en     = 1'b1;
      @(negedge CLOCK_50);
      pix_en     = 1'b0;
   endtask

   task automatic sweep_rows(input int ty);
      for (int y = 0; y <= ty; y++) strobe(0, y, 1'b1, 1'b1);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 2'd0;
      reset = 1'b1; pix_en = 1'b0; x_in = '0; y_in = '0;
      hs_in = 1'b1; vs_in = 1'b1; blank_n_in = 1'b0;
      repeat (3) @(negedge CLOCK_50);
      chk("rst_rgb", 32'(rgb), 32'(BLACK));
      chk("rst_hs", 32'(VGA_HS), 32'd1);
      chk("rst_vs", 32'(VGA_VS), 32'd1);
      chk("rst_blank", 32'(VGA_BLANK_N), 32'd0);
      chk("rst_addr", 32'(tile_addr), 32'd0);
      chk("rst_fs", 32'(frame_start), 32'd0);
      reset = 1'b0;

      // mid-line reset
      sweep_rows(25);
      for (int x = 1; x <= 5; x++) strobe(x, 25, 1'b1, 1'b1);
      chk("pre_rst_grey", 32'(rgb), 32'(GREY));
      @(negedge CLOCK_50);
      reset = 1'b1;
      repeat (2) @(negedge CLOCK_50);
      chk("mid_rst_rgb", 32'(rgb), 32'(BLACK));
      chk("mid_rst_blank", 32'(VGA_BLANK_N), 32'd0);
      chk("mid_rst_hs", 32'(VGA_HS), 32'd1);
      chk("mid_rst_addr", 32'(tile_addr), 32'd0);
      reset = 1'b0;
      for (int x = 50; x <= 52; x++) strobe(x, 25, 1'b1, 1'b1);
      chk("unsync_rgb", 32'(rgb), 32'(BLACK));
      chk("unsync_blank", 32'(VGA_BLANK_N), 32'd1);
      for (int x = 0; x <= 2; x++) strobe(x, 0, 1'b1, 1'b1);
      chk("first_valid_grey", 32'(rgb), 32'(GREY));

      // head at (row5,col7), body at (row5,col8); freeze at x=150
      mem[5*32+7] = 2'd2;
      mem[5*32+8] = 2'd1;
      sweep_rows(100);
      for (int x = 1; x <= 170; x++) begin
         int px;
         strobe(x, 100, 1'b1, 1'b1);
         px = x - 2;
         if (px >= 139 && px <= 162) begin
            if (px < 140)      chk($sformatf("line_px%0d", px), 32'(rgb), 32'(BLACK));
            else if (px < 160) chk($sformatf("line_px%0d", px), 32'(rgb), 32'(YELLOW));
            else               chk($sformatf("line_px%0d", px), 32'(rgb), 32'(GREEN));
         end
         if (x == 150) begin
            x_in = '0; y_in = '0; hs_in = 1'b0; blank_n_in = 1'b0;
            for (int c = 0; c < 10; c++) begin
               @(negedge CLOCK_50);
               chk("freeze_rgb", 32'(rgb), 32'(YELLOW));
               chk("freeze_addr", 32'(tile_addr), 32'd167);
               chk("freeze_hs", 32'(VGA_HS), 32'd1);
               chk("freeze_blank", 32'(VGA_BLANK_N), 32'd1);
            end
         end
      end

      // rest of line: right border, blanking, col saturation, hsync latency
      for (int x = 171; x <= 760; x++) begin
         strobe(x, 100, (x >= 656 && x < 752) ? 1'b0 : 1'b1, (x < 640) ? 1'b1 : 1'b0);
         if (x == 641) begin
            chk("px639_grey", 32'(rgb), 32'(GREY));
            chk("px639_blank", 32'(VGA_BLANK_N), 32'd1);
         end
         if (x == 642) begin
            chk("px640_rgb", 32'(rgb), 32'(BLACK));
            chk("px640_blank", 32'(VGA_BLANK_N), 32'd0);
         end
         if (x == 656) chk("hs_lat1", 32'(VGA_HS), 32'd1);
         if (x == 657) chk("hs_lat2", 32'(VGA_HS), 32'd1);
         if (x == 658) begin
            chk("hs_lat3", 32'(VGA_HS), 32'd0);
            chk("hs_rgb", 32'(rgb), 32'(BLACK));
         end
         if (x == 700) chk("col_sat_addr", 32'(tile_addr), 32'd191);
      end

      // border wins over tile code; blank wins over border
      mem[0] = 2'd1;
      sweep_rows(5);
      for (int x = 1; x <= 7; x++) strobe(x, 5, 1'b1, 1'b1);
      chk("border_grey", 32'(rgb), 32'(GREY));
      strobe(8, 5, 1'b1, 1'b0);
      strobe(9, 5, 1'b1, 1'b1);
      strobe(10, 5, 1'b1, 1'b1);
      chk("blank_rgb", 32'(rgb), 32'(BLACK));
      chk("blank_flag", 32'(VGA_BLANK_N), 32'd0);

      // food blink over 32 frames
      mem[10*32+10] = 2'd3;
      for (int k = 0; k < 32; k++) begin
         sweep_rows(200);
         for (int x = 1; x <= 202; x++) strobe(x, 200, 1'b1, 1'b1);
         chk($sformatf("food_f%0d", k), 32'(rgb), (k < 16) ? 32'(BLACK) : 32'(RED));
         @(negedge CLOCK_50);
         vs_in = 1'b0;
         @(negedge CLOCK_50);
         chk($sformatf("fs_hi_%0d", k), 32'(frame_start), 32'd1);
         @(negedge CLOCK_50);
         chk($sformatf("fs_lo_%0d", k), 32'(frame_start), 32'd0);
         vs_in = 1'b1;
         @(negedge CLOCK_50);
      end
      chk("fs_count", 32'(fs_cnt), 32'd32);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
